// File: rtl/vc2sd_pkg.sv
// Shared defaults and helpers for the vc2sd credit-link receiver.
package vc2sd_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_ASZ   = 2;

  // Pointer advance that wraps at lim, so depth need not be a power of two.
  function automatic int wrap_inc(input int ptr, input int lim);
    return (ptr + 1 >= lim) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/vc2sd_if.sv
// Credit-link input side and srdy/drdy output side of the vc2sd receiver.
interface vc2sd_if #(
  parameter int width = 8
);
  logic             c_vld;
  logic             c_cr;
  logic [width-1:0] c_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;
  logic             overflow;

  modport slave (
    input  c_vld, c_data, p_drdy,
    output c_cr, p_srdy, p_data, overflow
  );

  modport master (
    output c_vld, c_data, p_drdy,
    input  c_cr, p_srdy, p_data, overflow
  );
endinterface

// File: rtl/vc2sd_credit.sv
// Credit return engine: starts with depth credits owed, adds one per pop,
// and returns at most one per cycle on a registered c_cr.
module vc2sd_credit #(
  parameter int depth = 3,
  parameter int asz   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pop,
  output logic c_cr
);

  logic [asz:0] cr_pend;
  logic [asz:0] cr_pend_nxt;
  logic         issue;

  assign issue = (cr_pend != '0);

  always_comb begin
    cr_pend_nxt = cr_pend - (asz+1)'(issue) + (asz+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr_pend <= (asz+1)'(depth);
      c_cr    <= 1'b0;
    end else begin
      cr_pend <= cr_pend_nxt;
      c_cr    <= issue;
    end
  end

`ifndef SYNTHESIS
  // More credits owed than buffer slots means the sender broke the protocol.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cr_pend_nxt <= (asz+1)'(depth))
        else $error("vc2sd_credit: cr_pend would exceed depth");
    end
  end
`endif

endmodule

// File: rtl/vc2sd.sv
// Valid/credit to srdy/drdy receiver: small FIFO fed by a credit-managed link,
// returning one credit per consumed word plus an initial grant after reset.
module vc2sd
  import vc2sd_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH,
  parameter int asz   = DEF_ASZ
) (
  input logic     clk,
  input logic     reset,
  vc2sd_if.slave  bus
);

  if (depth < 1 || depth > (1 << asz)) begin : g_bad_params
    $error("vc2sd: depth must be in 1 .. 2**asz");
  end

  logic [width-1:0] storage [depth];
  logic [asz-1:0]   wrptr;
  logic [asz-1:0]   rdptr;
  logic [asz:0]     count;
  logic [asz:0]     count_nxt;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             overflow_q;

  assign full = (count == (asz+1)'(depth));
  assign pop  = (count != '0) & bus.p_drdy;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push = bus.c_vld & (~full | pop);
  assign drop = bus.c_vld & full & ~pop;

  always_comb begin
    count_nxt = count + (asz+1)'(push) - (asz+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrptr      <= '0;
      rdptr      <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wrptr <= asz'(wrap_inc(int'(wrptr), depth));
      if (pop)  rdptr <= asz'(wrap_inc(int'(rdptr), depth));
      count <= count_nxt;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) storage[wrptr] <= bus.c_data;
  end

  assign bus.p_srdy   = (count != '0);
  assign bus.p_data   = storage[rdptr];
  assign bus.overflow = overflow_q;

  vc2sd_credit #(
    .depth (depth),
    .asz   (asz)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .pop   (pop),
    .c_cr  (bus.c_cr)
  );

endmodule

// File: tb/tb_vc2sd.sv
// Directed and randomised checks of the vc2sd receiver with a credit-obeying sender.
module tb_vc2sd;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cr_seen = 0;

  logic [7:0] seq [3];

  always #5 clk = ~clk;

  vc2sd_if #(.width(8)) bus ();

  vc2sd #(
    .width (8),
    .depth (3),
    .asz   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.c_cr === 1'b1) cr_seen++;
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.c_vld  = 1'b1;
    bus.c_data = d;
    tick();
    bus.c_vld  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.c_vld = 1'b0;
    bus.c_data = '0;
    bus.p_drdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.p_srdy !== 1'b0 || bus.c_cr !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state srdy/cr/ovf got %b%b%b want 000", bus.p_srdy, bus.c_cr, bus.overflow);
    end
    reset = 1'b0;
    cr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.c_cr !== (i < 3) || bus.p_srdy !== 1'b0) begin
        errors++;
        $display("FAIL init_credit cycle %0d cr/srdy got %b%b want %b0", i + 1, bus.c_cr, bus.p_srdy, (i < 3));
      end
    end
    checks++;
    if (cr_seen != 3) begin
      errors++;
      $display("FAIL init_credit_total got %0d want 3", cr_seen);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      push_word(seq[i]);
      checks++;
      if (bus.p_srdy !== 1'b1 || bus.p_data !== 8'hA1 || bus.c_cr !== 1'b0) begin
        errors++;
        $display("FAIL fill word %0d srdy/data/cr got %b %h %b want 1 a1 0", i, bus.p_srdy, bus.p_data, bus.c_cr);
      end
    end
    tick();
    checks++;
    if (bus.p_data !== 8'hA1 || bus.c_cr !== 1'b0) begin
      errors++;
      $display("FAIL fill_hold data/cr got %h %b want a1 0", bus.p_data, bus.c_cr);
    end
  endtask

  task automatic test_drain();
    logic exp_cr [3];
    exp_cr = '{1'b0, 1'b1, 1'b1};
    cr_seen = 0;
    bus.p_drdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.p_srdy !== 1'b1 || bus.p_data !== seq[i]) begin
        errors++;
        $display("FAIL drain word %0d srdy/data got %b %h want 1 %h", i, bus.p_srdy, bus.p_data, seq[i]);
      end
      tick();
      checks++;
      if (bus.c_cr !== exp_cr[i]) begin
        errors++;
        $display("FAIL drain_cr pop %0d got %b want %b", i, bus.c_cr, exp_cr[i]);
      end
    end
    bus.p_drdy = 1'b0;
    checks++;
    if (bus.p_srdy !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty srdy got %b want 0", bus.p_srdy);
    end
    tick();
    tick();
    checks++;
    if (bus.c_cr !== 1'b0 || cr_seen != 3) begin
      errors++;
      $display("FAIL drain_credits cr/total got %b %0d want 0 3", bus.c_cr, cr_seen);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) push_word(seq[i]);
    push_word(8'hDD);
    checks++;
    if (bus.overflow !== 1'b1 || bus.p_data !== 8'hA1) begin
      errors++;
      $display("FAIL overflow_set ovf/data got %b %h want 1 a1", bus.overflow, bus.p_data);
    end
    tick();
    bus.p_drdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.p_srdy !== 1'b1 || bus.p_data !== seq[i]) begin
        errors++;
        $display("FAIL overflow_drain word %0d srdy/data got %b %h want 1 %h", i, bus.p_srdy, bus.p_data, seq[i]);
      end
      tick();
    end
    bus.p_drdy = 1'b0;
    checks++;
    if (bus.p_srdy !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after srdy/ovf got %b %b want 0 1", bus.p_srdy, bus.overflow);
    end
    repeat (3) tick();
  endtask

  task automatic test_mid_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    bus.p_drdy = 1'b1;
    checks++;
    if (bus.p_data !== 8'h11) begin
      errors++;
      $display("FAIL midrst_head got %h want 11", bus.p_data);
    end
    tick();
    bus.p_drdy = 1'b0;
    checks++;
    if (bus.p_srdy !== 1'b1 || bus.p_data !== 8'h22 || bus.c_cr !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre srdy/data/cr got %b %h %b want 1 22 0", bus.p_srdy, bus.p_data, bus.c_cr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.p_srdy !== 1'b0 || bus.c_cr !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async srdy/cr/ovf got %b%b%b want 000", bus.p_srdy, bus.c_cr, bus.overflow);
    end
    tick();
    tick();
    checks++;
    if (bus.c_cr !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold cr got %b want 0", bus.c_cr);
    end
    reset = 1'b0;
    cr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.p_srdy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale cycle %0d srdy got %b want 0", i + 1, bus.p_srdy);
      end
    end
    checks++;
    if (cr_seen != 3) begin
      errors++;
      $display("FAIL midrst_credits got %0d want 3", cr_seen);
    end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    int credit;
    int sent;
    int pops;
    int cycles;
    reset = 1'b1;
    bus.c_vld = 1'b0;
    bus.p_drdy = 1'b0;
    tick();
    reset = 1'b0;
    cr_seen = 0;
    credit = 0;
    sent = 0;
    pops = 0;
    cycles = 0;
    while ((sent < 200 || q.size() > 0) && cycles < 4000) begin
      if (sent < 200 && credit > 0 && $urandom_range(1, 0) == 1) begin
        bus.c_vld = 1'b1;
        bus.c_data = 8'($urandom_range(255, 0));
        q.push_back(bus.c_data);
        credit--;
        sent++;
      end else begin
        bus.c_vld = 1'b0;
      end
      bus.p_drdy = (sent >= 200) ? 1'b1 : 1'($urandom_range(1, 0));
      if (bus.p_srdy === 1'b1 && bus.p_drdy === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra word %h presented with nothing outstanding", bus.p_data);
        end else begin
          if (bus.p_data !== q[0]) begin
            errors++;
            $display("FAIL rnd_data pop %0d got %h want %h", pops, bus.p_data, q[0]);
          end
          void'(q.pop_front());
        end
        pops++;
      end
      tick();
      cycles++;
      if (bus.c_cr === 1'b1) credit++;
    end
    bus.c_vld = 1'b0;
    bus.p_drdy = 1'b0;
    repeat (4) begin
      tick();
      if (bus.c_cr === 1'b1) credit++;
    end
    checks++;
    if (cycles >= 4000 || q.size() != 0 || pops != 200) begin
      errors++;
      $display("FAIL rnd_complete cycles/left/pops got %0d %0d %0d want <4000 0 200", cycles, q.size(), pops);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rnd_overflow got %b want 0", bus.overflow);
    end
    checks++;
    if (cr_seen != pops + 3 || credit != 3) begin
      errors++;
      $display("FAIL rnd_credits total/held got %0d %0d want %0d 3", cr_seen, credit, pops + 3);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq = '{8'hA1, 8'hB2, 8'hC3};
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
